// File: rtl/video_timing_gen_if.sv
// Renderer-facing raster bus: the timing generator drives position/strobes,
// the renderer returns registered RGB aligned to the delayed de.
interface video_timing_gen_if;
  logic [11:0] px;
  logic [11:0] py;
  logic        de;
  logic        frame_start;
  logic        line_start;
  logic [7:0]  r_in;
  logic [7:0]  g_in;
  logic [7:0]  b_in;

  modport master (output px, py, de, frame_start, line_start,
                  input  r_in, g_in, b_in);
  modport slave  (input  px, py, de, frame_start, line_start,
                  output r_in, g_in, b_in);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator (default 1280x720p60) with sync/de delay line matched
// to renderer latency. Define VTG_PATTERN_EN to add an 8-bar test pattern.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_DLY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  video_timing_gen_if.master        rnd,
`ifdef VTG_PATTERN_EN
  input  logic                      pattern_sel,
`endif
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      de_o,
  output logic [7:0]                vid_r,
  output logic [7:0]                vid_g,
  output logic [7:0]                vid_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_TOT_M1 = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] V_TOT_M1 = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_pipe_dly
    $error("video_timing_gen: PIPE_DLY must be 0..7");
  end
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_totals
    $error("video_timing_gen: timing totals must fit in 12 bits");
  end

  logic [11:0] hc_q, hc_d, vc_q, vc_d;
  logic [11:0] px_q, py_q;
  logic        de_q, fs_q, ls_q, hs_q, vs_q;

  always_comb begin
    hc_d = hc_q + 12'd1;
    vc_d = vc_q;
    if (hc_q == H_TOT_M1) begin
      hc_d = '0;
      vc_d = (vc_q == V_TOT_M1) ? '0 : vc_q + 12'd1;
    end
    // Dropping en abandons the frame; the next run restarts at (0,0).
    if (!en) begin
      hc_d = '0;
      vc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
      px_q <= '0;
      py_q <= '0;
      de_q <= 1'b0;
      fs_q <= 1'b0;
      ls_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      if (en) begin
        px_q <= hc_q;
        py_q <= vc_q;
        de_q <= (hc_q < H_ACT) && (vc_q < V_ACT);
        fs_q <= (hc_q == '0) && (vc_q == '0);
        ls_q <= (hc_q == '0);
        hs_q <= (hc_q >= HS_BEG && hc_q < HS_END) ? HS_POL : ~HS_POL;
        vs_q <= (vc_q >= VS_BEG && vc_q < VS_END) ? VS_POL : ~VS_POL;
      end else begin
        px_q <= '0;
        py_q <= '0;
        de_q <= 1'b0;
        fs_q <= 1'b0;
        ls_q <= 1'b0;
        hs_q <= ~HS_POL;
        vs_q <= ~VS_POL;
      end
    end
  end

  assign rnd.px          = px_q;
  assign rnd.py          = py_q;
  assign rnd.de          = de_q;
  assign rnd.frame_start = fs_q;
  assign rnd.line_start  = ls_q;

  typedef struct packed {
`ifdef VTG_PATTERN_EN
    logic [11:0] px;
`endif
    logic de;
    logic hs;
    logic vs;
  } tap_t;

  tap_t raw, tap;

  always_comb begin
    raw    = '0;
    raw.de = de_q;
    raw.hs = hs_q;
    raw.vs = vs_q;
`ifdef VTG_PATTERN_EN
    raw.px = px_q;
`endif
  end

  // Delay line keeps shifting while en=0 so the outputs drain to idle.
  if (PIPE_DLY == 0) begin : g_nodly
    assign tap = raw;
  end else begin : g_dly
    tap_t [PIPE_DLY-1:0] dly_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          dly_q[i]    <= '0;
          dly_q[i].hs <= ~HS_POL;
          dly_q[i].vs <= ~VS_POL;
        end
      end else begin
        dly_q[0] <= raw;
        for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign tap = dly_q[PIPE_DLY-1];
  end

  assign de_o    = tap.de;
  assign hsync_o = tap.hs;
  assign vsync_o = tap.vs;

  logic [23:0] rgb;

`ifdef VTG_PATTERN_EN
  logic       pat_q;
  logic [2:0] bar;

  // Latched only while frame_start is high so a frame never mixes sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pat_q <= 1'b0;
    else if (fs_q) pat_q <= pattern_sel;
  end

  assign bar = 3'(tap.px / 12'(H_ACTIVE / 8));
`endif

  always_comb begin
    rgb = {rnd.r_in, rnd.g_in, rnd.b_in};
`ifdef VTG_PATTERN_EN
    if (pat_q) begin
      case (bar)
        3'd0:    rgb = 24'hFFFFFF;
        3'd1:    rgb = 24'hFFFF00;
        3'd2:    rgb = 24'h00FFFF;
        3'd3:    rgb = 24'h00FF00;
        3'd4:    rgb = 24'hFF00FF;
        3'd5:    rgb = 24'hFF0000;
        3'd6:    rgb = 24'h0000FF;
        default: rgb = 24'h000000;
      endcase
    end
`endif
    {vid_r, vid_g, vid_b} = de_o ? rgb : 24'h0;
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized en/RGB stimulus against a position-based raster model; expected
// outputs are queued per clock and a negedge monitor pops and compares them.
module tb_video_timing_gen;
  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PD = 2;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic hsync_o, vsync_o, de_o;
  logic [7:0] vid_r, vid_g, vid_b;
`ifdef VTG_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif

  always #5 clk = ~clk;

  video_timing_gen_if bus ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(PD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rnd(bus.master),
`ifdef VTG_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b)
  );

  typedef struct {bit de, hs, vs; int px;} raw_t;
  typedef struct {int px, py; bit de, fs, ls, de_o, hs_o, vs_o; int rgb;} exp_t;

  exp_t q[$];
  raw_t hist[$];
  int   pos;
  bit   fs_prev, pat_m;
  int   n_chk = 0, n_pass = 0;
  int   bar_rgb[8] = '{32'hFFFFFF, 32'hFFFF00, 32'h00FFFF, 32'h00FF00,
                       32'hFF00FF, 32'hFF0000, 32'h0000FF, 32'h000000};

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
  endtask

  task automatic model_reset();
    raw_t idle;
    idle = '{de: 1'b0, hs: 1'b0, vs: 1'b0, px: 0};
    hist.delete();
    for (int i = 0; i < PD; i++) hist.push_back(idle);
    pos = 0;
    fs_prev = 1'b0;
    pat_m = 1'b0;
  endtask

  // One clock edge of the reference: raster position is a linear clock count.
  task automatic model_edge(input bit en_s);
    exp_t e;
    raw_t r, d;
    int   h, v, rgb;
`ifdef VTG_PATTERN_EN
    if (fs_prev) pat_m = pattern_sel;
`endif
    e = '{px: 0, py: 0, de: 1'b0, fs: 1'b0, ls: 1'b0,
          de_o: 1'b0, hs_o: 1'b0, vs_o: 1'b0, rgb: 0};
    r = '{de: 1'b0, hs: 1'b0, vs: 1'b0, px: 0};
    if (en_s) begin
      h = pos % HT;
      v = (pos / HT) % VT;
      pos++;
      e.px = h; e.py = v;
      e.de = (h < HA) && (v < VA);
      e.fs = (h == 0) && (v == 0);
      e.ls = (h == 0);
      r = '{de: e.de, hs: (h >= HA + HF && h < HA + HF + HS),
            vs: (v >= VA + VF && v < VA + VF + VS), px: h};
    end else begin
      pos = 0;
    end
    fs_prev = e.fs;
    hist.push_back(r);
    d = hist.pop_front();
    e.de_o = d.de; e.hs_o = d.hs; e.vs_o = d.vs;
    rgb = $urandom_range(0, 32'hFFFFFF);
    {bus.r_in, bus.g_in, bus.b_in} = rgb[23:0];
    if (!d.de)      e.rgb = 0;
    else if (pat_m) e.rgb = bar_rgb[d.px / (HA / 8)];
    else            e.rgb = rgb;
    q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_px"}, int'(bus.px), 0);
    chk({tag, "_py"}, int'(bus.py), 0);
    chk({tag, "_de"}, int'(bus.de), 0);
    chk({tag, "_fs"}, int'(bus.frame_start), 0);
    chk({tag, "_ls"}, int'(bus.line_start), 0);
    chk({tag, "_hs_o"}, int'(hsync_o), 0);
    chk({tag, "_vs_o"}, int'(vsync_o), 0);
    chk({tag, "_de_o"}, int'(de_o), 0);
    chk({tag, "_vid"}, int'({vid_r, vid_g, vid_b}), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("px", int'(bus.px), e.px);
      chk("py", int'(bus.py), e.py);
      chk("de", int'(bus.de), int'(e.de));
      chk("frame_start", int'(bus.frame_start), int'(e.fs));
      chk("line_start", int'(bus.line_start), int'(e.ls));
      chk("de_o", int'(de_o), int'(e.de_o));
      chk("hsync_o", int'(hsync_o), int'(e.hs_o));
      chk("vsync_o", int'(vsync_o), int'(e.vs_o));
      chk("vid", int'({vid_r, vid_g, vid_b}), e.rgb);
    end
  end

  initial begin
    int off_cnt;
    off_cnt = 0;
    {bus.r_in, bus.g_in, bus.b_in} = 24'hAAAAAA;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    en = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      model_edge(en);
      if (c < 800) en = 1'b1;
      else if (off_cnt > 0) begin off_cnt--; en = 1'b0; end
      else if ($urandom_range(0, 299) == 0) begin
        off_cnt = $urandom_range(0, 4);
        en = 1'b0;
      end else en = 1'b1;
`ifdef VTG_PATTERN_EN
      if ($urandom_range(0, 49) == 0) pattern_sel = ~pattern_sel;
`endif
      if (c == 1700) begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        model_reset();
      end
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
